// File: rtl/truth_table_sequencer_if.sv
// Bundle between the truth-table sequencer and the two gate implementations
// it exercises: sweep request, the driven vector, both results, and verdict.
interface truth_table_sequencer_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic [N_IN-1:0] vec;
  logic            res_a;
  logic            res_b;
  logic            busy;
  logic            done;
  logic            equal;
  logic [N_IN:0]   mismatch_cnt;
  logic [N_IN-1:0] first_fail;
  logic            fail_valid;

  // Sequencer side: drives the vector and the verdict, samples the results.
  modport master (
    input  start, res_a, res_b,
    output vec, busy, done, equal, mismatch_cnt, first_fail, fail_valid
  );

  // Gate/requester side: issues start, returns results, reads the verdict.
  modport slave (
    output start, res_a, res_b,
    input  vec, busy, done, equal, mismatch_cnt, first_fail, fail_valid
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Exhaustive equivalence checker for two combinational implementations.
// Walks vec through 0..2^N_IN-1, holds each value SETTLE cycles, samples
// both results for one cycle, and accumulates a mismatch count, the first
// failing vector, and a pass/fail verdict.
module truth_table_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  truth_table_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = 1;
  localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            equal_q, equal_d;
  logic [N_IN:0]   mcnt_q, mcnt_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            fv_q, fv_d;
  logic            differ;
  logic [N_IN:0]   mcnt_inc;

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    equal_d  = equal_q;
    mcnt_d   = mcnt_q;
    ff_d     = ff_q;
    fv_d     = fv_q;
    // Case-inequality so an X/Z result from a gate counts as a failure.
    differ   = (bus.res_a !== bus.res_b);
    mcnt_inc = mcnt_q + {{N_IN{1'b0}}, differ};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          vec_d   = '0;
          cnt_d   = '0;
          mcnt_d  = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
          done_d  = 1'b0;
          equal_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        mcnt_d = mcnt_inc;
        if (differ && !fv_q) begin
          ff_d = vec_q;
          fv_d = 1'b1;
        end
        if (vec_q == VEC_LAST) begin
          // Last vector: verdict uses the count including this sample.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          equal_d = (mcnt_inc == '0);
        end else begin
          vec_d   = vec_q + VEC_ONE;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset clears any partial verdict at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      equal_q <= 1'b0;
      mcnt_q  <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      equal_q <= equal_d;
      mcnt_q  <= mcnt_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
    end
  end

  assign bus.vec          = vec_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.equal        = equal_q;
  assign bus.mismatch_cnt = mcnt_q;
  assign bus.first_fail   = ff_q;
  assign bus.fail_valid   = fv_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: one instance at N_IN=2/SETTLE=1
// and one at N_IN=3/SETTLE=3, fed by behavioural gate pairs. Expected sweep
// results are pushed to a scoreboard on start and popped when done rises.
module tb_truth_table_sequencer;

  typedef struct {
    int   edges;
    logic eq;
    int   cnt;
    int   ff;
    logic fv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_r = 1'b0;
  int   sel = 0;
  int   mode = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  truth_table_sequencer_if #(.N_IN(2)) ia ();
  truth_table_sequencer_if #(.N_IN(3)) ib ();

  truth_table_sequencer #(.N_IN(2), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.master)
  );
  truth_table_sequencer #(.N_IN(3), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.master)
  );

  always #5 clk = ~clk;

  // Gate pair under test, selected by mode:
  // 0 equal 2-input NAND, 1 res_b stuck low at vec==2, 2 constant 1 vs 0,
  // 3 De Morgan pair for a 3-input NAND.
  function automatic logic gate_a(input int m, input int v);
    logic [7:0] b;
    b = 8'(v);
    case (m)
      2:       gate_a = 1'b1;
      3:       gate_a = ~(b[0] & b[1] & b[2]);
      default: gate_a = ~(b[0] & b[1]);
    endcase
  endfunction

  function automatic logic gate_b(input int m, input int v);
    logic [7:0] b;
    b = 8'(v);
    case (m)
      1:       gate_b = (v == 2) ? 1'b0 : ~(b[0] & b[1]);
      2:       gate_b = 1'b0;
      3:       gate_b = ~b[0] | ~b[1] | ~b[2];
      default: gate_b = ~(b[0] & b[1]);
    endcase
  endfunction

  function automatic exp_t model(input int m, input int n, input int s);
    exp_t e;
    e.cnt = 0; e.ff = 0; e.fv = 1'b0;
    for (int v = 0; v < (1 << n); v++) begin
      if (gate_a(m, v) !== gate_b(m, v)) begin
        e.cnt++;
        if (!e.fv) begin e.ff = v; e.fv = 1'b1; end
      end
    end
    e.eq = (e.cnt == 0);
    e.edges = (1 << n) * (s + 1);
    return e;
  endfunction

  assign ia.start = start_r & (sel == 0);
  assign ib.start = start_r & (sel == 1);
  assign ia.res_a = gate_a(mode, int'(ia.vec));
  assign ia.res_b = gate_b(mode, int'(ia.vec));
  assign ib.res_a = gate_a(mode, int'(ib.vec));
  assign ib.res_b = gate_b(mode, int'(ib.vec));

  logic [7:0] o_vec, o_cnt, o_ff;
  logic       o_busy, o_done, o_eq, o_fv;

  // Observation mux for whichever instance is being exercised.
  always_comb begin
    if (sel == 0) begin
      o_vec = 8'(ia.vec); o_cnt = 8'(ia.mismatch_cnt); o_ff = 8'(ia.first_fail);
      o_busy = ia.busy; o_done = ia.done; o_eq = ia.equal; o_fv = ia.fail_valid;
    end else begin
      o_vec = 8'(ib.vec); o_cnt = 8'(ib.mismatch_cnt); o_ff = 8'(ib.first_fail);
      o_busy = ib.busy; o_done = ib.done; o_eq = ib.equal; o_fv = ib.fail_valid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " vec"}, 32'(o_vec), 0);
    chk({tag, " busy"}, 32'(o_busy), 0);
    chk({tag, " done"}, 32'(o_done), 0);
    chk({tag, " equal"}, 32'(o_eq), 0);
    chk({tag, " cnt"}, 32'(o_cnt), 0);
    chk({tag, " first_fail"}, 32'(o_ff), 0);
    chk({tag, " fail_valid"}, 32'(o_fv), 0);
  endtask

  // Run one sweep on instance s; optionally re-pulse start mid-sweep.
  task automatic sweep(input string tag, input int s, input int m, input bit poke);
    exp_t e;
    int   n, st, edges, v, last;
    n = (s == 0) ? 2 : 3;
    st = (s == 0) ? 1 : 3;
    last = (1 << n) - 1;
    sel = s;
    mode = m;
    sb.push_back(model(m, n, st));
    @(negedge clk); start_r = 1'b1;
    @(posedge clk); #1; start_r = 1'b0;
    chk({tag, " busy@start"}, 32'(o_busy), 1);
    chk({tag, " done@start"}, 32'(o_done), 0);
    chk({tag, " vec@start"}, 32'(o_vec), 0);
    edges = 0;
    while (o_done !== 1'b1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (poke && edges == 2) start_r = 1'b1;
      if (poke && edges == 3) start_r = 1'b0;
      v = edges / (st + 1);
      if (v > last) v = last;
      chk($sformatf("%s vec@%0d", tag, edges), 32'(o_vec), 32'(v));
    end
    e = sb.pop_front();
    chk({tag, " done_edges"}, 32'(edges), 32'(e.edges));
    chk({tag, " done"}, 32'(o_done), 1);
    chk({tag, " busy"}, 32'(o_busy), 0);
    chk({tag, " equal"}, 32'(o_eq), 32'(e.eq));
    chk({tag, " cnt"}, 32'(o_cnt), 32'(e.cnt));
    chk({tag, " first_fail"}, 32'(o_ff), 32'(e.ff));
    chk({tag, " fail_valid"}, 32'(o_fv), 32'(e.fv));
    chk({tag, " vec_final"}, 32'(o_vec), 32'(last));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    sel = 0; chk_all_zero("rst_a");
    sel = 1; chk_all_zero("rst_b");
    @(negedge clk); rst_n = 1'b1;

    sweep("clean", 0, 0, 1'b0);
    sweep("one_fail", 0, 1, 1'b0);
    sweep("all_fail", 0, 2, 1'b0);
    sweep("restart_ignored", 0, 0, 1'b1);

    // Hold after DONE with start low.
    repeat (3) @(posedge clk);
    #1;
    chk("hold done", 32'(o_done), 1);
    chk("hold vec", 32'(o_vec), 3);

    // Abort a failing sweep with reset after five edges.
    sel = 0; mode = 2;
    @(negedge clk); start_r = 1'b1;
    @(posedge clk); #1; start_r = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_abort cnt", 32'(o_cnt), 2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    @(negedge clk); rst_n = 1'b1;
    sweep("after_abort", 0, 1, 1'b0);

    sweep("wide", 1, 3, 1'b0);
    sweep("wide_again", 1, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
